// File: rtl/aq_ifu_btb_upd_ctrl.sv
// Write-side controller for the IFU branch target buffer: serialises BJU update/delete
// requests and CP0 invalidate-all into one-hot per-entry update/clear strobes.
module aq_ifu_btb_upd_ctrl #(
    parameter int ENTRY_NUM  = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  cp0_yy_clk_en,
    input  logic                  cp0_ifu_icg_en,
    input  logic                  pad_yy_icg_scan_en,
    input  logic                  bju_btb_upd_vld,
    input  logic                  bju_btb_upd_del,
    input  logic [ADDR_WIDTH-1:0] bju_btb_upd_tag,
    input  logic [ADDR_WIDTH-1:0] bju_btb_upd_tgt,
    output logic                  btb_bju_upd_rdy,
    input  logic                  cp0_ifu_btb_inv,
    output logic                  btb_cp0_inv_done,
    output logic [ADDR_WIDTH-1:0] btb_wr_acc_tag,
    input  logic [ENTRY_NUM-1:0]  btb_entry_wr_hit,
    output logic [ADDR_WIDTH-1:0] btb_upd_tag,
    output logic [ADDR_WIDTH-1:0] btb_upd_tgt,
    output logic [ENTRY_NUM-1:0]  btb_entry_upd,
    output logic [ENTRY_NUM-1:0]  btb_entry_updg,
    output logic [ENTRY_NUM-1:0]  btb_entry_clr,
    output logic [ENTRY_NUM-1:0]  btb_entry_clrg,
    output logic                  btb_upd_busy
);

    localparam int PW = $clog2(ENTRY_NUM);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        WRITE,
        INVALL
    } state_e;

    state_e                  state_q;
    logic                    inv_pend_q;
    logic                    inv_done_q;
    logic [PW-1:0]           rr_ptr_q;
    logic [PW-1:0]           rr_ptr_d;
    logic [ADDR_WIDTH-1:0]   tag_q;
    logic [ADDR_WIDTH-1:0]   tgt_q;
    logic                    del_q;
    logic [ENTRY_NUM-1:0]    upd_q;
    logic [ENTRY_NUM-1:0]    clr_q;

    logic                    accept;
    logic                    payload_clk_en;
    logic                    payload_ld;
    logic                    hit_any;
    logic [ENTRY_NUM-1:0]    hit_oh;
    logic [ENTRY_NUM-1:0]    victim_oh;

    assign btb_bju_upd_rdy = (state_q == IDLE) && !inv_pend_q && !cp0_ifu_btb_inv;
    assign accept          = btb_bju_upd_rdy && bju_btb_upd_vld;

    // Same enable equation as the gated_clk_cell: global enable, local/module enable, scan override.
    assign payload_clk_en  = (cp0_yy_clk_en && (accept || cp0_ifu_icg_en)) || pad_yy_icg_scan_en;
    assign payload_ld      = payload_clk_en && accept;

    // Two's-complement trick isolates the lowest set bit, so multiple hits pick the lowest index.
    assign hit_any   = |btb_entry_wr_hit;
    assign hit_oh    = btb_entry_wr_hit & (~btb_entry_wr_hit + ENTRY_NUM'(1));
    assign victim_oh = ENTRY_NUM'(1) << rr_ptr_q;
    assign rr_ptr_d  = rr_ptr_q + PW'(1);

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            tag_q <= '0;
            tgt_q <= '0;
            del_q <= 1'b0;
        end else if (payload_ld) begin
            tag_q <= bju_btb_upd_tag;
            tgt_q <= bju_btb_upd_tgt;
            del_q <= bju_btb_upd_del;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q    <= IDLE;
            inv_pend_q <= 1'b0;
            inv_done_q <= 1'b0;
            rr_ptr_q   <= '0;
            upd_q      <= '0;
            clr_q      <= '0;
        end else begin
            inv_done_q <= (state_q == INVALL);
            upd_q      <= '0;
            clr_q      <= '0;
            if (cp0_ifu_btb_inv && (state_q != INVALL)) begin
                inv_pend_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= LOOKUP;
                    end else if (inv_pend_q || cp0_ifu_btb_inv) begin
                        state_q <= INVALL;
                        clr_q   <= '1;
                    end
                end
                LOOKUP: begin
                    state_q <= WRITE;
                    if (del_q) begin
                        if (hit_any) begin
                            clr_q <= hit_oh;
                        end
                    end else if (hit_any) begin
                        upd_q <= hit_oh;
                    end else begin
                        upd_q    <= victim_oh;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                WRITE: begin
                    if (inv_pend_q) begin
                        state_q <= INVALL;
                        clr_q   <= '1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                INVALL: begin
                    state_q    <= IDLE;
                    rr_ptr_q   <= '0;
                    inv_pend_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign btb_wr_acc_tag   = tag_q;
    assign btb_upd_tag      = tag_q;
    assign btb_upd_tgt      = tgt_q;
    assign btb_entry_upd    = upd_q;
    assign btb_entry_updg   = upd_q;
    assign btb_entry_clr    = clr_q;
    assign btb_entry_clrg   = clr_q;
    assign btb_cp0_inv_done = inv_done_q;
    assign btb_upd_busy     = (state_q != IDLE) || inv_pend_q;

endmodule

// File: tb/tb_aq_ifu_btb_upd_ctrl.sv
// Bench for aq_ifu_btb_upd_ctrl: a behavioural BTB entry array answers lookups, and a
// transaction-level model predicts strobes, handshakes and invalidate timing per cycle.
module tb_aq_ifu_btb_upd_ctrl;

    localparam int EN = 16;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          clk_en = 1'b1;
    logic          icg_en = 1'b0;
    logic          scan_en = 1'b0;
    logic          vld = 1'b0;
    logic          del = 1'b0;
    logic [AW-1:0] tag = '0;
    logic [AW-1:0] tgt = '0;
    logic          inv = 1'b0;
    logic          rdy;
    logic          inv_done;
    logic [AW-1:0] acc_tag;
    logic [EN-1:0] wr_hit;
    logic [AW-1:0] upd_tag;
    logic [AW-1:0] upd_tgt;
    logic [EN-1:0] e_upd;
    logic [EN-1:0] e_updg;
    logic [EN-1:0] e_clr;
    logic [EN-1:0] e_clrg;
    logic          busy;

    aq_ifu_btb_upd_ctrl #(.ENTRY_NUM(EN), .ADDR_WIDTH(AW)) dut (
        .forever_cpuclk     (clk),
        .cpurst_b           (rst_n),
        .cp0_yy_clk_en      (clk_en),
        .cp0_ifu_icg_en     (icg_en),
        .pad_yy_icg_scan_en (scan_en),
        .bju_btb_upd_vld    (vld),
        .bju_btb_upd_del    (del),
        .bju_btb_upd_tag    (tag),
        .bju_btb_upd_tgt    (tgt),
        .btb_bju_upd_rdy    (rdy),
        .cp0_ifu_btb_inv    (inv),
        .btb_cp0_inv_done   (inv_done),
        .btb_wr_acc_tag     (acc_tag),
        .btb_entry_wr_hit   (wr_hit),
        .btb_upd_tag        (upd_tag),
        .btb_upd_tgt        (upd_tgt),
        .btb_entry_upd      (e_upd),
        .btb_entry_updg     (e_updg),
        .btb_entry_clr      (e_clr),
        .btb_entry_clrg     (e_clrg),
        .btb_upd_busy       (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_invall = 0;
    int n_done = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Behavioural BTB entry array, written only through the DUT strobes or a bench preload.
    logic          env_v[EN];
    logic [AW-1:0] env_tag[EN];
    logic [AW-1:0] env_tgt[EN];
    logic          pl_en = 1'b0;
    int            pl_idx = 0;
    logic [AW-1:0] pl_tag = '0;
    logic [AW-1:0] pl_tgt = '0;

    initial for (int i = 0; i < EN; i++) begin
        env_v[i] = 1'b0; env_tag[i] = '0; env_tgt[i] = '0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < EN; i++) begin
            if (e_clrg[i] && e_clr[i]) env_v[i] <= 1'b0;
            if (e_updg[i] && e_upd[i]) begin
                env_v[i]   <= 1'b1;
                env_tag[i] <= upd_tag;
                env_tgt[i] <= upd_tgt;
            end
        end
        if (pl_en) begin
            env_v[pl_idx]   <= 1'b1;
            env_tag[pl_idx] <= pl_tag;
            env_tgt[pl_idx] <= pl_tgt;
        end
    end

    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < EN; i++) wr_hit[i] = env_v[i] && (env_tag[i] == acc_tag);
    end

    // Transaction-level model: contents the BTB should hold and what each cycle must show.
    int            m_busy_to = 0;
    int            m_invall_cyc = -1;
    int            m_write_cyc = -1;
    int            m_rr = 0;
    bit            m_pend = 1'b0;
    logic [AW-1:0] m_acc_tag = '0;
    bit            ref_v[EN];
    logic [AW-1:0] ref_tag[EN];
    logic [AW-1:0] ref_tgt[EN];
    bit            pw_valid = 1'b0;
    bit            pw_clr = 1'b0;
    int            pw_cyc = 0;
    int            pw_idx = 0;
    logic [AW-1:0] pw_tag = '0;
    logic [AW-1:0] pw_tgt = '0;
    logic [EN-1:0] exp_upd[int];
    logic [EN-1:0] exp_clr[int];
    logic [AW-1:0] exp_tgt[int];
    bit            exp_done[int];

    initial for (int i = 0; i < EN; i++) begin
        ref_v[i] = 1'b0; ref_tag[i] = '0; ref_tgt[i] = '0;
    end

    task automatic start_invall(input int c);
        m_invall_cyc = c;
        exp_clr[c] = '1;
        exp_done[c+1] = 1'b1;
        m_busy_to = c + 1;
        m_pend = 1'b0;
        m_rr = 0;
        for (int i = 0; i < EN; i++) ref_v[i] = 1'b0;
    endtask

    task automatic model_accept(input int k);
        int hit;
        int idx;
        hit = -1;
        for (int i = EN - 1; i >= 0; i--)
            if (ref_v[i] && ref_tag[i] == tag) hit = i;
        m_acc_tag = tag;
        m_write_cyc = k + 2;
        m_busy_to = k + 3;
        if (del) begin
            if (hit >= 0) begin
                exp_clr[k+2] = EN'(1) << hit;
                pw_valid = 1'b1; pw_clr = 1'b1; pw_cyc = k + 2; pw_idx = hit;
            end
        end else begin
            idx = (hit >= 0) ? hit : m_rr;
            if (hit < 0) m_rr = (m_rr + 1) % EN;
            exp_upd[k+2] = EN'(1) << idx;
            exp_tgt[k+2] = tgt;
            pw_valid = 1'b1; pw_clr = 1'b0; pw_cyc = k + 2; pw_idx = idx;
            pw_tag = tag; pw_tgt = tgt;
        end
    endtask

    always @(posedge clk) begin
        int  k;
        bit  old_pend;
        bit  started;
        k = cyc;
        cyc = cyc + 1;
        if (pl_en) begin
            ref_v[pl_idx] = 1'b1; ref_tag[pl_idx] = pl_tag; ref_tgt[pl_idx] = pl_tgt;
        end
        if (!rst_n) begin
            m_busy_to = 0; m_invall_cyc = -1; m_write_cyc = -1; m_rr = 0;
            m_pend = 1'b0; m_acc_tag = '0; pw_valid = 1'b0;
            exp_upd.delete(); exp_clr.delete(); exp_tgt.delete(); exp_done.delete();
        end else begin
            if (pw_valid && k == pw_cyc) begin
                pw_valid = 1'b0;
                if (pw_clr) ref_v[pw_idx] = 1'b0;
                else begin
                    ref_v[pw_idx] = 1'b1; ref_tag[pw_idx] = pw_tag; ref_tgt[pw_idx] = pw_tgt;
                end
            end
            old_pend = m_pend;
            started = 1'b0;
            if (k == m_invall_cyc) begin
                m_pend = 1'b0;
            end else begin
                if (k >= m_busy_to) begin
                    if (!old_pend && !inv && vld) model_accept(k);
                    else if (old_pend || inv) begin start_invall(k + 1); started = 1'b1; end
                end else if (k == m_write_cyc && old_pend) begin
                    start_invall(k + 1); started = 1'b1;
                end
                if (inv && !started) m_pend = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [EN-1:0] eu;
        logic [EN-1:0] ec;
        bit            ed;
        if (rst_n) begin
            eu = exp_upd.exists(cyc) ? exp_upd[cyc] : '0;
            ec = exp_clr.exists(cyc) ? exp_clr[cyc] : '0;
            ed = exp_done.exists(cyc) ? exp_done[cyc] : 1'b0;
            check("upd", e_upd, eu);
            check("updg", e_updg, eu);
            check("clr", e_clr, ec);
            check("clrg", e_clrg, ec);
            check("inv_done", inv_done, ed);
            check("rdy", rdy, (cyc >= m_busy_to) && !m_pend && !inv);
            check("busy", busy, (cyc < m_busy_to) || m_pend);
            check("acc_tag", acc_tag, m_acc_tag);
            check("upd_tag", upd_tag, m_acc_tag);
            if (exp_tgt.exists(cyc)) check("upd_tgt", upd_tgt, exp_tgt[cyc]);
            if (e_clr == '1) n_invall++;
            if (inv_done) n_done++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy();
        int n;
        n = 0;
        while (!rdy && n < 20) begin step(); n++; end
        if (!rdy) check("rdy_timeout", 1'b0, 1'b1);
    endtask

    task automatic issue(input logic d, input logic [AW-1:0] t, input logic [AW-1:0] g);
        wait_rdy();
        vld = 1'b1; del = d; tag = t; tgt = g;
        step();
        vld = 1'b0;
    endtask

    // Returns the strobes seen during the WRITE cycle and leaves the bench in the cycle after it.
    task automatic req(input logic d, input logic [AW-1:0] t, input logic [AW-1:0] g,
                       output logic [EN-1:0] u, output logic [EN-1:0] c);
        issue(d, t, g);
        step();
        u = e_upd;
        c = e_clr;
        step();
    endtask

    task automatic preload(input int i, input logic [AW-1:0] t, input logic [AW-1:0] g);
        pl_en = 1'b1; pl_idx = i; pl_tag = t; pl_tgt = g;
        step();
        pl_en = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [EN-1:0] u;
        logic [EN-1:0] c;
        int a;
        int b;
        #1 rst_n = 1'b0;
        #2;
        check("rst_rdy", rdy, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_acc_tag", acc_tag, 16'h0000);
        check("rst_upd", e_upd, 16'h0000);
        check("rst_clr", e_clr, 16'h0000);
        check("rst_done", inv_done, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        req(1'b0, 16'h1000, 16'h2000, u, c);
        check("first_miss_upd", u, 16'h0001);
        check("entry0_valid", env_v[0], 1'b1);
        check("entry0_tag", env_tag[0], 16'h1000);

        for (int i = 0; i < 16; i++) begin
            req(1'b0, 16'h1100 + 16'(i), 16'h4000 + 16'(i), u, c);
            check("wrap_victim", u, 16'h0001 << ((i + 1) % 16));
        end
        check("wrap_entry0_tag", env_tag[0], 16'h110F);

        preload(5, 16'h1000, 16'h2222);
        req(1'b0, 16'h1000, 16'h3000, u, c);
        check("hit_upd", u, 16'h0020);
        check("hit_tgt", env_tgt[5], 16'h3000);
        req(1'b0, 16'h7777, 16'h0777, u, c);
        check("rr_unchanged", u, 16'h0002);

        req(1'b1, 16'h1000, 16'h0000, u, c);
        check("del_hit_clr", c, 16'h0020);
        check("del_hit_upd", u, 16'h0000);
        req(1'b1, 16'hDEAD, 16'h0000, u, c);
        check("del_miss_upd", u, 16'h0000);
        check("del_miss_clr", c, 16'h0000);
        check("del_miss_rdy", rdy, 1'b1);

        preload(3, 16'hABCD, 16'h0003);
        preload(9, 16'hABCD, 16'h0009);
        req(1'b0, 16'hABCD, 16'h1234, u, c);
        check("multi_hit_lowest", u, 16'h0008);

        // Invalidate and update presented together in IDLE.
        vld = 1'b1; del = 1'b0; tag = 16'h5555; tgt = 16'h0555; inv = 1'b1;
        #2 check("inv_blocks_rdy", rdy, 1'b0);
        step();
        inv = 1'b0;
        check("invall_clr", e_clr, 16'hFFFF);
        check("invall_clrg", e_clrg, 16'hFFFF);
        step();
        check("inv_done_pulse", inv_done, 1'b1);
        check("rdy_after_inv", rdy, 1'b1);
        step();
        vld = 1'b0;
        step();
        check("upd_after_inv", u == u ? e_upd : e_upd, 16'h0001);

        // Invalidate during LOOKUP: the write finishes first.
        step();
        a = n_invall; b = n_done;
        issue(1'b0, 16'h6001, 16'h0601);
        inv = 1'b1;
        step();
        inv = 1'b0;
        check("lookup_inv_write", e_upd, 16'h0002);
        check("lookup_inv_noclr", e_clr, 16'h0000);
        step();
        check("lookup_inv_invall", e_clr, 16'hFFFF);
        step();
        check("lookup_inv_done", inv_done, 1'b1);
        repeat (3) step();
        check("lookup_inv_one_pass", n_invall - a, 1);

        // Second pulse while INVALL is running is absorbed.
        a = n_invall; b = n_done;
        inv = 1'b1;
        step();
        step();
        inv = 1'b0;
        repeat (4) step();
        check("absorb_invall_count", n_invall - a, 1);
        check("absorb_done_count", n_done - b, 1);

        // Pulses in LOOKUP and WRITE merge into one invalidate.
        a = n_invall; b = n_done;
        issue(1'b0, 16'h6002, 16'h0602);
        inv = 1'b1;
        step();
        check("merge_write_upd", e_upd, 16'h0001);
        step();
        inv = 1'b0;
        repeat (5) step();
        check("merge_invall_count", n_invall - a, 1);
        check("merge_done_count", n_done - b, 1);

        // Asynchronous reset in the middle of WRITE.
        issue(1'b0, 16'h6003, 16'h0603);
        step();
        check("pre_reset_write", e_upd, 16'h0001);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("reset_upd_zero", e_upd, 16'h0000);
        check("reset_clr_zero", e_clr, 16'h0000);
        check("reset_busy", busy, 1'b0);
        check("reset_rdy", rdy, 1'b1);
        check("reset_acc_tag", acc_tag, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        req(1'b0, 16'h6004, 16'h0604, u, c);
        check("rr_after_reset", u, 16'h0001);

        repeat (3) step();
        for (int i = 0; i < EN; i++) begin
            check("final_valid", env_v[i], ref_v[i]);
            if (ref_v[i]) begin
                check("final_tag", env_tag[i], ref_tag[i]);
                check("final_tgt", env_tgt[i], ref_tgt[i]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
